move_ser: RTL and testbench

Frame serializer on the transmit side of the inter-board link. Accepts one 16-bit command frame (4-bit opcode + 12-bit payload) per handshake from the game controller and drives it out as a gated serial clock/data pair; the receiving board's deserializer samples data on the rising edge of the link clock. Runs entirely on the system clock; the link clock is generated by division.

---
 rtl/move_ser.sv | 165 ++++++++++++++++
 tb/tb_move_ser.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_ser.sv
// move_ser: transmit-side frame serializer for the inter-board link.
// Captures {opcode, payload} on a valid/ready handshake and shifts it out MSB
// first as a gated link clock/data pair derived from the system clock.
// The receiver samples data_out on the rising edge of clock_out.
// Optional feature: define MOVE_SER_PARITY_EN to append an even-parity bit
// (XOR of all 16 frame bits) after payload bit 0, giving 17 link bits.
module move_ser #(
    parameter int CLK_DIV    = 4,  // system cycles per link-clock half-period
    parameter int GAP_CYCLES = 8   // idle cycles between frames
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tx_valid,
    input  logic [3:0]  tx_opcode,
    input  logic [11:0] tx_payload,
    output logic        tx_ready,
    output logic        data_out,
    output logic        clock_out,
    output logic        busy,
    output logic        done
);

`ifdef MOVE_SER_PARITY_EN
    localparam int NBITS = 17;
`else
    localparam int NBITS = 16;
`endif

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [4:0]  BIT_LAST = 5'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;      // half-period divider
    logic [4:0]  bit_q, bit_d;      // index of the bit on the wire
    logic [15:0] gap_q, gap_d;      // inter-frame gap counter
    logic [15:0] shreg_q, shreg_d;  // remaining bits, next one at [15]
    logic        high_q, high_d;    // 1 while in the high phase of a bit
    logic        data_q, data_d;
    logic        clk_q, clk_d;
    logic        done_q, done_d;

    logic [15:0] frame;
    logic        fill_bit;

    assign frame = {tx_opcode, tx_payload};

    // The bit shifted in behind the frame ends up on the wire as bit 16,
    // which is exactly where the parity bit belongs.
`ifdef MOVE_SER_PARITY_EN
    assign fill_bit = ^frame;
`else
    assign fill_bit = 1'b0;
`endif

    // Next-state and output logic for the IDLE/SHIFT/GAP sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        high_d  = high_q;
        data_d  = data_q;
        clk_d   = clk_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                clk_d  = 1'b0;
                data_d = 1'b0;
                if (tx_valid) begin
                    state_d = SHIFT;
                    data_d  = frame[15];
                    shreg_d = {frame[14:0], fill_bit};
                    div_d   = '0;
                    bit_d   = '0;
                    high_d  = 1'b0;
                end
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!high_q) begin
                        high_d = 1'b1;
                        clk_d  = 1'b1;
                    end else begin
                        high_d = 1'b0;
                        clk_d  = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = GAP;
                            data_d  = 1'b0;
                            gap_d   = '0;
                        end else begin
                            // Data only moves at the start of a low phase.
                            bit_d   = bit_q + 5'd1;
                            data_d  = shreg_q[15];
                            shreg_d = {shreg_q[14:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end

            GAP: begin
                clk_d  = 1'b0;
                data_d = 1'b0;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                clk_d   = 1'b0;
                data_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; a partial frame is dropped.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
            high_q  <= 1'b0;
            data_q  <= 1'b0;
            clk_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            high_q  <= high_d;
            data_q  <= data_d;
            clk_q   <= clk_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign data_out  = data_q;
    assign clock_out = clk_q;
    assign done      = done_q;

endmodule

// File: tb/tb_move_ser.sv
// tb_move_ser: scoreboard bench for move_ser with CLK_DIV=2, GAP_CYCLES=8.
// Accepts are recorded at the clock edge and pushed as expected frames; a
// negedge monitor rebuilds each frame from clock_out rising edges and checks
// it against the queue when done pulses.
module tb_move_ser;

    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 8;
`ifdef MOVE_SER_PARITY_EN
    localparam int NBITS = 17;
`else
    localparam int NBITS = 16;
`endif
    // Accept edge T to done cycle: 1 + 2*NBITS*CLK_DIV + GAP_CYCLES.
    localparam int FRAME_CYC = 1 + 2 * NBITS * CLK_DIV + GAP_CYCLES;

    logic        clock;
    logic        reset;
    logic        tx_valid;
    logic [3:0]  tx_opcode;
    logic [11:0] tx_payload;
    logic        tx_ready;
    logic        data_out;
    logic        clock_out;
    logic        busy;
    logic        done;

    move_ser #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_opcode  (tx_opcode),
        .tx_payload (tx_payload),
        .tx_ready   (tx_ready),
        .data_out   (data_out),
        .clock_out  (clock_out),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [16:0] word;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        obs_e;
    exp_t        mon_e;
    int          acc_cyc[$];
    logic [16:0] rx_words[$];
    int          n_acc = 0;
    int          cyc   = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [16:0] exp_word(input logic [15:0] f);
`ifdef MOVE_SER_PARITY_EN
        return {f, ^f};
`else
        return {1'b0, f};
`endif
    endfunction

    // Accept observer: records every handshake and its expected frame.
    always @(posedge clock) begin
        if (!reset && tx_valid && tx_ready) begin
            obs_e.word     = exp_word({tx_opcode, tx_payload});
            obs_e.done_cyc = cyc + FRAME_CYC;
            sb.push_back(obs_e);
            acc_cyc.push_back(cyc);
            n_acc++;
        end
        cyc++;
    end

    // Monitor: rebuilds frames from the link pins and scores them on done.
    logic        prev_clk  = 1'b0;
    logic        prev_data = 1'b0;
    logic [16:0] bits      = '0;
    int          nb        = 0;
    logic        hi_change = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            bits      = '0;
            nb        = 0;
            hi_change = 1'b0;
            prev_clk  = 1'b0;
            prev_data = 1'b0;
        end else begin
            if (clock_out && !prev_clk) begin
                bits = {bits[15:0], data_out};
                nb++;
            end
            if (clock_out && prev_clk && (data_out !== prev_data))
                hi_change = 1'b1;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("frame_bits", 32'(bits), 32'(mon_e.word));
                    check("frame_edges", nb, NBITS);
                    check("done_cycle", cyc, mon_e.done_cyc);
                    check("data_stable_high", 32'(hi_change), 32'd0);
                    rx_words.push_back(bits);
                end
                bits      = '0;
                nb        = 0;
                hi_change = 1'b0;
            end
            prev_clk  = clock_out;
            prev_data = data_out;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [11:0] pl);
        tx_opcode  = op;
        tx_payload = pl;
        tx_valid   = 1'b1;
        tick();
        tx_valid   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done !== 1'b1; k++) tick();
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic check_last_rx(input string name, input logic [16:0] exp);
        check({name, "_rx_present"}, 32'(rx_words.size() > 0), 32'd1);
        if (rx_words.size() > 0)
            check(name, 32'(rx_words[rx_words.size()-1]), 32'(exp));
    endtask

    int t0;
    int t1;
    int ready_low;
    int hi_cnt;
    int base;
    int run;
    int max_run;
    logic seen_hi;
    logic [11:0] pl2;

    initial begin
        reset      = 1'b1;
        tx_valid   = 1'b0;
        tx_opcode  = '0;
        tx_payload = '0;

        // Reset and idle behaviour.
        repeat (3) tick();
        reset = 1'b0;
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_clock_out", 32'(clock_out), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        hi_cnt = 0;
        repeat (50) begin
            tick();
            if (clock_out) hi_cnt++;
        end
        check("idle_no_clock", hi_cnt, 0);

        // Single frame A / 5C3: done at T+73, tx_ready low T+1..T+72.
        send(4'hA, 12'h5C3);
        t0 = acc_cyc[acc_cyc.size()-1];
        check("first_shift_busy", 32'(busy), 32'd1);
        check("first_shift_data", 32'(data_out), 32'd1);
        check("first_shift_clk", 32'(clock_out), 32'd0);
        ready_low = 0;
        for (int k = 0; k < 200 && done !== 1'b1; k++) begin
            if (!tx_ready) ready_low++;
            tick();
        end
        check("single_done_seen", 32'(done), 32'd1);
        check("single_done_at", cyc - t0, FRAME_CYC);
        check("single_ready_low", ready_low, FRAME_CYC - 1);
        tick();
`ifdef MOVE_SER_PARITY_EN
        check_last_rx("single_word", 17'h14B86);
`else
        check_last_rx("single_word", 17'h0A5C3);
`endif
        repeat (3) tick();

`ifdef MOVE_SER_PARITY_EN
        // Parity: 0001 -> parity 1, A5C3 -> parity 0, done at T+77.
        send(4'h0, 12'h001);
        t0 = acc_cyc[acc_cyc.size()-1];
        wait_done(200);
        check("par1_done_at", cyc - t0, 77);
        tick();
        check_last_rx("par1_word", 17'h00003);
        repeat (2) tick();
        send(4'hA, 12'h5C3);
        wait_done(200);
        tick();
        check_last_rx("par0_word", 17'h14B86);
        repeat (2) tick();
`endif

        // Busy rejection: valid held, payload changing every cycle.
        tx_opcode = 4'h3;
        tx_valid  = 1'b1;
        base      = n_acc;
        for (int k = 0; k < 400 && n_acc < base + 2; k++) begin
            tx_payload = 12'(cyc * 37);
            tick();
        end
        tx_valid = 1'b0;
        check("busy_two_accepts", n_acc - base, 2);
        t0 = acc_cyc[base];
        t1 = acc_cyc[base + 1];
        check("busy_accept_gap", t1 - t0, FRAME_CYC);
        pl2 = 12'(t1 * 37);
        wait_done(300);
        tick();
        check_last_rx("busy_second_word", exp_word({4'h3, pl2}));
        if (rx_words.size() > 1)
            check("busy_first_word", 32'(rx_words[rx_words.size()-2]),
                  32'(exp_word({4'h3, 12'(t0 * 37)})));
        repeat (3) tick();

        // Back-to-back: low run between frames = GAP + done/IDLE cycle + CLK_DIV.
        tx_opcode  = 4'h5;
        tx_payload = 12'h0F0;
        tx_valid   = 1'b1;
        base       = n_acc;
        run        = 0;
        max_run    = 0;
        seen_hi    = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (n_acc >= base + 2) tx_valid = 1'b0;
            if (clock_out) begin
                if (seen_hi && run > max_run) max_run = run;
                seen_hi = 1'b1;
                run     = 0;
                if (n_acc >= base + 2) break;
            end else if (seen_hi) begin
                run++;
            end
        end
        tx_valid = 1'b0;
        check("b2b_low_run", max_run, GAP_CYCLES + 1 + CLK_DIV);
        wait_done(300);
        repeat (3) tick();

        // Mid-frame reset during the bit 7 high phase.
        send(4'hC, 12'h123);
        t0 = acc_cyc[acc_cyc.size()-1];
        for (int k = 0; k < 100 && cyc < t0 + 31; k++) tick();
        check("b7_high_phase", 32'(clock_out), 32'd1);
        reset = 1'b1;
        tick();
        check("mrst_clock_out", 32'(clock_out), 32'd0);
        check("mrst_data_out", 32'(data_out), 32'd0);
        check("mrst_tx_ready", 32'(tx_ready), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        send(4'h6, 12'hABC);
        wait_done(200);
        tick();
`ifdef MOVE_SER_PARITY_EN
        check_last_rx("post_rst_word", 17'h0D579);
`else
        check_last_rx("post_rst_word", 17'h06ABC);
`endif

        repeat (20) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
